// File: rtl/irq_status_ctrl.sv
// Interrupt status controller: per-channel pending/status capture with masked
// lowest-index arbitration, a frozen presentation until ack, and a holdoff gap.
module irq_status_ctrl #(
  parameter int                NUM_CH    = 8,
  parameter int                STATUS_W  = 8,
  parameter logic [NUM_CH-1:0] EDGE_MASK = '0,
  parameter int                HOLDOFF   = 2,
  localparam int               ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            irq_src,
  input  logic [NUM_CH*STATUS_W-1:0]   status_in,
  input  logic [NUM_CH-1:0]            mask,
  input  logic                         ack,
  output logic                         irq,
  output logic [ID_W-1:0]              irq_id,
  output logic [STATUS_W-1:0]          status,
  output logic [NUM_CH-1:0]            pending
);

  // Handshake: irq acts as valid and ack as a one-cycle ready; a transfer
  // happens only on a cycle where state is ASSERT and ack is 1. Until then
  // irq, irq_id and status are frozen; ack outside ASSERT has no effect.

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

  state_t              state;
  logic [NUM_CH-1:0]   prev_src;
  logic [NUM_CH-1:0]   set_cond;
  logic [NUM_CH-1:0]   clr;
  logic [NUM_CH-1:0]   req;
  logic [STATUS_W-1:0] stat_q [NUM_CH];
  logic [3:0]          hold_cnt;
  logic [ID_W-1:0]     sel_id;

  assign pending = pending_q_out();

  logic [NUM_CH-1:0] pend_q;

  function automatic logic [NUM_CH-1:0] pending_q_out();
    return pend_q;
  endfunction

  always_comb begin
    // Edge channels need a 0->1 transition; level channels set whenever high.
    set_cond = irq_src & ~(EDGE_MASK & prev_src);
    req      = pend_q & mask;
    clr      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      clr[k] = (state == ASSERT) && ack && (irq_id == ID_W'(k));
    end
    sel_id = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) sel_id = ID_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      irq      <= 1'b0;
      irq_id   <= '0;
      status   <= '0;
      pend_q   <= '0;
      prev_src <= '0;
      hold_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) stat_q[k] <= '0;
    end else begin
      prev_src <= irq_src;
      // A set on the ack cycle wins over the clear and reloads the status.
      pend_q <= (pend_q & ~clr) | set_cond;
      for (int k = 0; k < NUM_CH; k++) begin
        if (set_cond[k] && (!pend_q[k] || clr[k]))
          stat_q[k] <= status_in[k*STATUS_W +: STATUS_W];
      end

      case (state)
        IDLE: begin
          if (|req) begin
            state  <= ASSERT;
            irq    <= 1'b1;
            irq_id <= sel_id;
            status <= stat_q[sel_id];
          end
        end
        ASSERT: begin
          if (ack) begin
            state    <= HOLD;
            irq      <= 1'b0;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/irq_status_ctrl.md
IRQ_STATUS_CTRL -- requirements
Module: irq_status_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- NUM_CH, 8, number of interrupt channels (1..32)
- STATUS_W, 8, status word width per channel
- EDGE_MASK, all 0 (NUM_CH bits), per-channel mode: 1 = rising-edge, 0 = level
- HOLDOFF, 2, minimum irq-low cycles between consecutive assertions (1..15)
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all logic samples on posedge clk
- rst_n  in  1  reset; synchronous, active-low
- irq_src  in  NUM_CH  raw interrupt requests, one bit per channel
- status_in  in  NUM_CH*STATUS_W  per-channel status; channel k in bits [k*STATUS_W +: STATUS_W]
- mask  in  NUM_CH  1 = channel enabled
- ack  in  1  single-cycle clear of the currently presented channel
- irq  out  1  aggregated interrupt, registered
- irq_id  out  ID_W  presented channel index; ID_W = max(1, clog2(NUM_CH))
- status  out  STATUS_W  status latched for the presented channel
- pending  out  NUM_CH  pending bits, masked and unmasked

Function
REQ-003 Edge channel k SHALL set pending[k] on any cycle where irq_src[k]=1 and irq_src[k] was 0 in the previous cycle.
REQ-004 Level channel k SHALL set pending[k] on any cycle where irq_src[k]=1.
REQ-005 On the cycle pending[k] goes from 0 to 1, status_in for channel k SHALL be latched into a per-channel status register; while pending[k] is already 1, the register SHALL hold its value.
REQ-006 The FSM SHALL have three states: IDLE, ASSERT, HOLD.
REQ-007 IDLE -> ASSERT SHALL occur when (pending & mask) != 0. On this transition the lowest-index set bit is selected, irq_id and status are loaded, and irq=1 from the next cycle.
REQ-008 In ASSERT, irq, irq_id and status SHALL stay frozen until ack=1, whatever happens to mask, irq_src or other pending bits.
REQ-009 On ack in ASSERT, pending[irq_id] SHALL clear. The FSM SHALL go to HOLD, and irq SHALL be 0 from the next cycle.
REQ-010 If a set condition for channel irq_id occurs on the same cycle as ack, the set SHALL win: pending stays 1 and the status register reloads.
REQ-011 HOLD SHALL last exactly HOLDOFF cycles, counted by a 4-bit counter, then the FSM returns to IDLE. Re-assertion SHALL NOT occur earlier than HOLDOFF+1 cycles after ack.
REQ-012 ack SHALL be ignored in IDLE and HOLD.
REQ-013 Masked channels SHALL still set pending, but SHALL NOT be selected.
REQ-014 Unmasking a pending channel while in IDLE SHALL trigger REQ-007 on that cycle.
REQ-015 In IDLE, irq_id and status SHALL hold their last values.

Reset
REQ-016 While rst_n=0 at posedge clk, the following SHALL be cleared: the FSM to IDLE, and irq, irq_id, status, pending, the status registers, the HOLD counter and the edge-history registers, all to 0.
REQ-017 Reset asserted mid-ASSERT or mid-HOLD SHALL abort the state immediately.
REQ-018 The first post-reset cycle SHALL treat previous irq_src as 0, so a source already high counts as a rising edge.

Verification
REQ-019 Level: NUM_CH=8, mask=FF, irq_src[3]=1 with status_in[3]=8'hA5 -> irq=1, irq_id=3, status=A5 two cycles later.
REQ-020 Priority: irq_src[5] and [2] rise together -> irq_id=2 first. After ack plus HOLDOFF=2 idle cycles, irq_id=5.
REQ-021 Edge: EDGE_MASK[0]=1, irq_src[0] held high for 10 cycles, ack once -> exactly one assertion, and pending[0]=0 after ack.
REQ-022 Mask: irq_src[1]=1 with mask[1]=0 -> irq stays 0 and pending[1]=1. Set mask[1]=1 -> irq=1 one cycle later.
REQ-023 Collision: level channel 4 held high, ack -> pending[4] stays 1 and irq re-asserts exactly HOLDOFF+1 cycles after ack.
REQ-024 Reset mid-ASSERT: rst_n=0 for 1 cycle while irq=1 -> next cycle irq=0 and pending=0.
